// File: rtl/prog_fetch_unit_if.sv
// Signal bundle shared by the fetch unit, the serial programming slave and the decode stage.
// The fetch unit takes the slave side; the driving agent takes the master side.
interface prog_fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 32,
    parameter int CNT_W  = 16
);
    localparam int LANES = INST_W / 8;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    logic              i_prog_mode;
    logic              i_wr_en;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [LW-1:0]     i_wr_lane;
    logic [7:0]        i_wr_byte;
    logic [7:0]        o_rd_byte;
    logic [CNT_W-1:0]  o_wr_count;
    logic              i_stall;
    logic              i_jump;
    logic [ADDR_W-1:0] i_jump_addr;
    logic [INST_W-1:0] o_inst;
    logic [ADDR_W-1:0] o_pc;
    logic              o_inst_valid;
    logic              o_halted;

    modport master (
        output i_prog_mode, i_wr_en, i_wr_addr, i_wr_lane, i_wr_byte,
        output i_stall, i_jump, i_jump_addr,
        input  o_rd_byte, o_wr_count, o_inst, o_pc, o_inst_valid, o_halted
    );

    modport slave (
        input  i_prog_mode, i_wr_en, i_wr_addr, i_wr_lane, i_wr_byte,
        input  i_stall, i_jump, i_jump_addr,
        output o_rd_byte, o_wr_count, o_inst, o_pc, o_inst_valid, o_halted
    );
endinterface

// File: rtl/prog_fetch_unit.sv
// Byte-programmable instruction store with a single-stage fetch pipeline.
// PROG mode loads/reads bytes; RUN mode fetches sequentially with stall, jump and halt detection.
module prog_fetch_unit #(
    parameter int                ADDR_W    = 8,
    parameter int                INST_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [INST_W-1:0] HALT_INST = '1,
    parameter int                CNT_W     = 16
) (
    input logic              i_clk,
    input logic              i_rst,
    prog_fetch_unit_if.slave bus
);
    localparam int          DEPTH   = 1 << ADDR_W;
    localparam int          LANES   = INST_W / 8;
    localparam int          LW      = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW:0] LANES_L = (LW + 1)'(LANES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROG,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] fetch_addr_q;
    logic [ADDR_W-1:0] pc_q;
    logic [INST_W-1:0] inst_q;
    logic              valid_q;
    logic              halted_q;
    logic [7:0]        rd_byte_q;
    logic [CNT_W-1:0]  wr_count_q;

    logic                  lane_ok_d;
    logic                  wr_ok_d;
    logic [LANES-1:0][7:0] lane_rd_d;
    logic [INST_W-1:0]     fetch_word_d;
    logic [7:0]            rd_byte_d;

    // Lane indices past the last byte of the word are silently dropped.
    assign lane_ok_d = ({1'b0, bus.i_wr_lane} < LANES_L);
    assign wr_ok_d   = (state_q == ST_PROG) && bus.i_wr_en && lane_ok_d && !i_rst;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];

        always_ff @(posedge i_clk) begin
            if (wr_ok_d && (bus.i_wr_lane == LW'(gi))) begin
                mem[bus.i_wr_addr] <= bus.i_wr_byte;
            end
        end

        assign lane_rd_d[gi]              = mem[bus.i_wr_addr];
        assign fetch_word_d[8*gi +: 8]    = mem[fetch_addr_q];
    end

    always_comb begin
        rd_byte_d = 8'h00;
        for (int i = 0; i < LANES; i++) begin
            if (bus.i_wr_lane == LW'(i)) begin
                rd_byte_d = lane_rd_d[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            fetch_addr_q <= RESET_PC;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
            rd_byte_q    <= 8'h00;
            wr_count_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_prog_mode) begin
                        state_q    <= ST_PROG;
                        wr_count_q <= '0;
                    end else begin
                        state_q      <= ST_RUN;
                        fetch_addr_q <= RESET_PC;
                    end
                end
                ST_PROG: begin
                    // Memory write lands on this same edge, so the readback sees the old byte.
                    rd_byte_q <= rd_byte_d;
                    if (wr_ok_d && (wr_count_q != '1)) begin
                        wr_count_q <= wr_count_q + CNT_W'(1);
                    end
                    if (!bus.i_prog_mode) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.i_prog_mode) begin
                        state_q    <= ST_PROG;
                        valid_q    <= 1'b0;
                        wr_count_q <= '0;
                    end else if (bus.i_jump) begin
                        fetch_addr_q <= bus.i_jump_addr;
                        valid_q      <= 1'b0;
                    end else if (bus.i_stall) begin
                        state_q <= ST_RUN;
                    end else if (valid_q && (inst_q == HALT_INST)) begin
                        state_q  <= ST_HALT;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        inst_q       <= fetch_word_d;
                        pc_q         <= fetch_addr_q;
                        valid_q      <= 1'b1;
                        fetch_addr_q <= fetch_addr_q + ADDR_W'(1);
                    end
                end
                ST_HALT: begin
                    if (bus.i_prog_mode) begin
                        state_q    <= ST_PROG;
                        halted_q   <= 1'b0;
                        wr_count_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_inst       = inst_q;
    assign bus.o_pc         = pc_q;
    assign bus.o_inst_valid = valid_q;
    assign bus.o_halted     = halted_q;
    assign bus.o_rd_byte    = rd_byte_q;
    assign bus.o_wr_count   = wr_count_q;
endmodule

// File: tb/tb_prog_fetch_unit.sv
// Randomised scoreboard bench: a word-array memory model predicts the fetch stream,
// a negedge monitor per instance pops and compares each newly presented instruction.
module tb_prog_fetch_unit;
    logic clk = 1'b0;
    logic rst8;
    logic rst4;
    always #5 clk = ~clk;

    prog_fetch_unit_if #(.ADDR_W(8), .INST_W(32), .CNT_W(16)) if8 ();
    prog_fetch_unit_if #(.ADDR_W(4), .INST_W(24), .CNT_W(16)) if4 ();

    prog_fetch_unit #(.ADDR_W(8), .INST_W(32)) dut8 (.i_clk(clk), .i_rst(rst8), .bus(if8.slave));
    prog_fetch_unit #(.ADDR_W(4), .INST_W(24)) dut4 (.i_clk(clk), .i_rst(rst4), .bus(if4.slave));

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mem8 [256];
    logic [23:0] mem4 [16];
    fetch_t      q8[$];
    fetch_t      q4[$];
    int          acc8 = 0;
    int          acc4 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push8(input int a);
        fetch_t f;
        f.pc   = 32'(a);
        f.inst = mem8[a];
        q8.push_back(f);
    endtask

    task automatic push4(input int a);
        fetch_t f;
        f.pc   = 32'(a);
        f.inst = {8'h00, mem4[a]};
        q4.push_back(f);
    endtask

    task automatic wr8(input int a, input int l, input logic [7:0] b);
        if8.i_wr_en   = 1'b1;
        if8.i_wr_addr = 8'(a);
        if8.i_wr_lane = 2'(l);
        if8.i_wr_byte = b;
        mem8[a][8*l +: 8] = b;
        acc8++;
        step();
        if8.i_wr_en = 1'b0;
    endtask

    task automatic wr4(input int a, input int l, input logic [7:0] b);
        if4.i_wr_en   = 1'b1;
        if4.i_wr_addr = 4'(a);
        if4.i_wr_lane = 2'(l);
        if4.i_wr_byte = b;
        if (l < 3) begin
            mem4[a][8*l +: 8] = b;
            acc4++;
        end
        step();
        if4.i_wr_en = 1'b0;
    endtask

    task automatic chk_reset8(input string tag);
        chk({tag, " valid"},  32'(if8.o_inst_valid), 32'd0);
        chk({tag, " pc"},     32'(if8.o_pc),         32'd0);
        chk({tag, " inst"},   if8.o_inst,            32'd0);
        chk({tag, " halted"}, 32'(if8.o_halted),     32'd0);
        chk({tag, " rd"},     32'(if8.o_rd_byte),    32'd0);
        chk({tag, " count"},  32'(if8.o_wr_count),   32'd0);
    endtask

    // A held presentation is one where the previous edge saw an effective stall.
    logic   hold8 = 1'b0;
    logic   hold4 = 1'b0;
    fetch_t last8;
    fetch_t last4;

    always @(negedge clk) begin
        if (if8.o_inst_valid === 1'b1) begin
            if (hold8) begin
                chk("dut8 held pc", 32'(if8.o_pc), last8.pc);
                chk("dut8 held inst", if8.o_inst, last8.inst);
            end else if (q8.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut8 unexpected fetch actual pc=0x%0h required none", if8.o_pc);
            end else begin
                last8 = q8.pop_front();
                $display("dut8 fetch pc=0x%0h inst=0x%0h expect pc=0x%0h inst=0x%0h",
                         if8.o_pc, if8.o_inst, last8.pc, last8.inst);
                chk("dut8 fetch pc", 32'(if8.o_pc), last8.pc);
                chk("dut8 fetch inst", if8.o_inst, last8.inst);
            end
        end
        hold8 = (if8.o_inst_valid === 1'b1) && if8.i_stall && !if8.i_jump && !if8.i_prog_mode && !rst8;
    end

    always @(negedge clk) begin
        if (if4.o_inst_valid === 1'b1) begin
            if (hold4) begin
                chk("dut4 held pc", 32'(if4.o_pc), last4.pc);
                chk("dut4 held inst", 32'(if4.o_inst), last4.inst);
            end else if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut4 unexpected fetch actual pc=0x%0h required none", if4.o_pc);
            end else begin
                last4 = q4.pop_front();
                $display("dut4 fetch pc=0x%0h inst=0x%0h expect pc=0x%0h inst=0x%0h",
                         if4.o_pc, if4.o_inst, last4.pc, last4.inst);
                chk("dut4 fetch pc", 32'(if4.o_pc), last4.pc);
                chk("dut4 fetch inst", 32'(if4.o_inst), last4.inst);
            end
        end
        hold4 = (if4.o_inst_valid === 1'b1) && if4.i_stall && !if4.i_jump && !if4.i_prog_mode && !rst4;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic [23:0] w4;
        int          a;
        int          l;
        int          r;
        int          pc4;

        rst8 = 1'b1;
        rst4 = 1'b1;
        if8.i_prog_mode = 1'b1; if8.i_wr_en = 1'b0; if8.i_wr_addr = '0; if8.i_wr_lane = '0;
        if8.i_wr_byte = '0; if8.i_stall = 1'b0; if8.i_jump = 1'b0; if8.i_jump_addr = '0;
        if4.i_prog_mode = 1'b1; if4.i_wr_en = 1'b0; if4.i_wr_addr = '0; if4.i_wr_lane = '0;
        if4.i_wr_byte = '0; if4.i_stall = 1'b0; if4.i_jump = 1'b0; if4.i_jump_addr = '0;
        step();
        step();
        rst8 = 1'b0;
        chk_reset8("dut8 reset");
        step();

        // Four words lane by lane, then a wider region for the run phases.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) wr8(i, j, 8'($urandom));
        chk("dut8 count after 16 writes", 32'(if8.o_wr_count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            a = (i < 4) ? (4 + i) : (8'h40 + i - 4);
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h0;
            for (int j = 0; j < 4; j++) wr8(a, j, w[8*j +: 8]);
        end

        wr8(5, 2, 8'hA5);
        step();
        chk("dut8 readback A5", 32'(if8.o_rd_byte), 32'hA5);
        wr8(5, 2, 8'h3C);
        chk("dut8 read-before-write", 32'(if8.o_rd_byte), 32'hA5);
        step();
        chk("dut8 readback 3C", 32'(if8.o_rd_byte), 32'h3C);
        for (int i = 0; i < 4; i++) begin
            a = $urandom_range(0, 7);
            l = $urandom_range(0, 3);
            if8.i_wr_addr = 8'(a);
            if8.i_wr_lane = 2'(l);
            step();
            chk("dut8 random readback", 32'(if8.o_rd_byte), 32'(mem8[a][8*l +: 8]));
        end
        chk("dut8 count total", 32'(if8.o_wr_count), 32'(acc8));

        if8.i_prog_mode = 1'b0;
        step();
        step();
        chk("dut8 no fetch before first edge", 32'(if8.o_inst_valid), 32'd0);
        for (int i = 0; i < 6; i++) push8(i);
        repeat (6) step();

        if8.i_stall = 1'b1;
        repeat (3) step();
        chk("dut8 stall pc", 32'(if8.o_pc), 32'd5);
        if8.i_stall = 1'b0;
        push8(6);
        push8(7);
        repeat (2) step();

        if8.i_jump      = 1'b1;
        if8.i_jump_addr = 8'h40;
        step();
        chk("dut8 jump bubble", 32'(if8.o_inst_valid), 32'd0);
        if8.i_jump = 1'b0;
        for (int i = 0; i < 4; i++) push8(8'h40 + i);
        repeat (4) step();
        chk("dut8 after jump pc", 32'(if8.o_pc), 32'h43);

        rst8 = 1'b1;
        if8.i_prog_mode = 1'b1;
        step();
        chk_reset8("dut8 mid-run reset");
        rst8 = 1'b0;
        step();

        acc8 = 0;
        for (int j = 0; j < 4; j++) wr8(2, j, 8'hFF);
        chk("dut8 count after re-entry", 32'(if8.o_wr_count), 32'd4);
        if8.i_prog_mode = 1'b0;
        step();
        step();
        for (int i = 0; i < 3; i++) push8(i);
        repeat (4) step();
        chk("dut8 halted", 32'(if8.o_halted), 32'd1);
        chk("dut8 halt valid", 32'(if8.o_inst_valid), 32'd0);
        chk("dut8 halt pc", 32'(if8.o_pc), 32'd2);
        chk("dut8 halt inst", if8.o_inst, 32'hFFFF_FFFF);
        if8.i_jump      = 1'b1;
        if8.i_jump_addr = 8'h40;
        if8.i_stall     = 1'b1;
        repeat (2) step();
        if8.i_jump  = 1'b0;
        if8.i_stall = 1'b0;
        chk("dut8 halt ignores jump", 32'(if8.o_halted), 32'd1);
        chk("dut8 halt pc held", 32'(if8.o_pc), 32'd2);
        if8.i_prog_mode = 1'b1;
        step();
        chk("dut8 halt to prog", 32'(if8.o_halted), 32'd0);

        // Narrow instance: 24-bit words (lane 3 is out of range) and a 16-word store.
        rst4 = 1'b0;
        chk("dut4 reset valid", 32'(if4.o_inst_valid), 32'd0);
        chk("dut4 reset count", 32'(if4.o_wr_count), 32'd0);
        step();
        for (int i = 0; i < 16; i++) begin
            w4 = 24'($urandom);
            if (w4 == 24'hFF_FFFF) w4 = 24'h0;
            for (int j = 0; j < 3; j++) wr4(i, j, w4[8*j +: 8]);
            if ((i % 5) == 0) wr4(i, 3, 8'($urandom));
        end
        chk("dut4 count ignores lane 3", 32'(if4.o_wr_count), 32'(acc4));
        if4.i_wr_addr = 4'd3;
        if4.i_wr_lane = 2'd3;
        step();
        chk("dut4 lane 3 readback", 32'(if4.o_rd_byte), 32'd0);
        if4.i_wr_lane = 2'd1;
        step();
        chk("dut4 lane 1 readback", 32'(if4.o_rd_byte), 32'(mem4[3][15:8]));

        if4.i_prog_mode = 1'b0;
        step();
        step();
        for (int i = 0; i < 17; i++) push4(i % 16);
        repeat (17) step();
        chk("dut4 wrap pc", 32'(if4.o_pc), 32'd0);

        pc4 = 1;
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                if4.i_jump      = 1'b1;
                if4.i_stall     = 1'($urandom_range(0, 1));
                pc4             = $urandom_range(0, 15);
                if4.i_jump_addr = 4'(pc4);
            end else if (r < 4) begin
                if4.i_jump  = 1'b0;
                if4.i_stall = 1'b1;
            end else begin
                if4.i_jump  = 1'b0;
                if4.i_stall = 1'b0;
                push4(pc4);
                pc4 = (pc4 + 1) % 16;
            end
            step();
        end
        if4.i_jump      = 1'b0;
        if4.i_stall     = 1'b0;
        if4.i_prog_mode = 1'b1;
        step();
        step();

        chk("dut8 scoreboard drained", 32'(q8.size()), 32'd0);
        chk("dut4 scoreboard drained", 32'(q4.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
